wb_stage: RTL and testbench

- Final pipeline stage. Consumes the registered MEM-stage latch and selects the result: load data or ALU result.
- Drives the register-file write port in DE, which also serves as the bypass source for DE and AGEX.
- Keeps retirement bookkeeping: retired count, last PC, in-order check and halt detection.
- Signals halt to FE so fetch stops after the terminating instruction commits.

---
 rtl/wb_stage_pkg.sv | 15 +
 rtl/wb_commit_hist.sv | 46 ++++
 rtl/wb_stage.sv | 127 ++++++++++++
 tb/tb_wb_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: internal opcodes, halt word,
// FSM state type.
package wb_stage_pkg;

  localparam logic [5:0]  ADD_I         = 6'd1;
  localparam logic [5:0]  LW_I          = 6'd10;
  localparam logic [5:0]  SW_I          = 6'd11;
  localparam logic [31:0] HALT_INST_DEF = 32'h0000_0073;

  typedef enum logic {
    RUN,
    HALTED
  } wb_state_e;

endpackage

// File: rtl/wb_commit_hist.sv
// Circular buffer of committed PCs; newest entry is read at rd_idx = 0.
// Only instantiated by wb_stage when WB_COMMIT_HIST_EN is defined.
module wb_commit_hist #(
  parameter int unsigned DBITS      = 32,
  parameter int unsigned HIST_DEPTH = 8,
  localparam int unsigned IW        = $clog2(HIST_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DBITS-1:0] push_pc,
  input  logic [IW-1:0]    rd_idx,
  output logic [DBITS-1:0] rd_pc
);

  logic [DBITS-1:0] mem_q [HIST_DEPTH];
  logic [DBITS-1:0] mem_d [HIST_DEPTH];
  logic [IW-1:0]    wptr_q, wptr_d;
  logic [IW-1:0]    rd_ptr;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    if (push) begin
      mem_d[wptr_q] = push_pc;
      wptr_d        = wptr_q + IW'(1);
    end
  end

  // Power-of-two depth: pointer arithmetic wraps naturally
  always_comb begin
    rd_ptr = wptr_q - IW'(1) - rd_idx;
    rd_pc  = mem_q[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      for (int unsigned i = 0; i < HIST_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: result select, regfile write port, retirement bookkeeping
// and halt detection. Define WB_COMMIT_HIST_EN to add the commit-PC history.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned          DBITS      = 32,
  parameter int unsigned          INSTBITS   = 32,
  parameter int unsigned          REGNOBITS  = 5,
  parameter int unsigned          IOPBITS    = 6,
  parameter logic [INSTBITS-1:0]  HALT_INST  = INSTBITS'(HALT_INST_DEF),
  parameter int unsigned          HIST_DEPTH = 8,
  localparam int unsigned LATCH_W = 1 + INSTBITS + 4*DBITS + IOPBITS + REGNOBITS + 1,
  localparam int unsigned HIDX_W  = $clog2(HIST_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LATCH_W-1:0]   from_MEM_latch,
  output logic                 wb_wr_en,
  output logic [REGNOBITS-1:0] wb_wregno,
  output logic [DBITS-1:0]     wb_wval,
  output logic                 from_WB_to_FE,
  output logic [DBITS-1:0]     retired_count,
  output logic [DBITS-1:0]     last_pc,
  output logic                 halted,
  output logic                 order_err,
  input  logic [HIDX_W-1:0]    hist_idx,
  output logic [DBITS-1:0]     hist_pc
);

  localparam int unsigned RD_LSB    = 0;
  localparam int unsigned IC_LSB    = DBITS;
  localparam int unsigned WR_BIT    = 2*DBITS;
  localparam int unsigned WRN_LSB   = WR_BIT + 1;
  localparam int unsigned ALU_LSB   = WRN_LSB + REGNOBITS;
  localparam int unsigned OP_LSB    = ALU_LSB + DBITS;
  localparam int unsigned PC_LSB    = OP_LSB + IOPBITS;
  localparam int unsigned INST_LSB  = PC_LSB + DBITS;
  localparam int unsigned VALID_BIT = INST_LSB + INSTBITS;

  logic                 l_valid, l_wr_reg;
  logic [INSTBITS-1:0]  l_inst;
  logic [DBITS-1:0]     l_pc, l_alu, l_ic, l_rd;
  logic [IOPBITS-1:0]   l_op;
  logic [REGNOBITS-1:0] l_wregno;

  assign l_valid  = from_MEM_latch[VALID_BIT];
  assign l_inst   = from_MEM_latch[INST_LSB +: INSTBITS];
  assign l_pc     = from_MEM_latch[PC_LSB   +: DBITS];
  assign l_op     = from_MEM_latch[OP_LSB   +: IOPBITS];
  assign l_alu    = from_MEM_latch[ALU_LSB  +: DBITS];
  assign l_wregno = from_MEM_latch[WRN_LSB  +: REGNOBITS];
  assign l_wr_reg = from_MEM_latch[WR_BIT];
  assign l_ic     = from_MEM_latch[IC_LSB   +: DBITS];
  assign l_rd     = from_MEM_latch[RD_LSB   +: DBITS];

  wb_state_e        state_q, state_d;
  logic [DBITS-1:0] retired_q, retired_d;
  logic [DBITS-1:0] last_pc_q, last_pc_d;
  logic [DBITS-1:0] expect_q, expect_d;
  logic             order_err_q, order_err_d;
  logic             commit;

  always_comb begin
    commit    = l_valid && (state_q != HALTED) && !reset;
    wb_wr_en  = commit && l_wr_reg && (l_wregno != '0);
    wb_wregno = reset ? '0 : l_wregno;
    wb_wval   = '0;
    if (!reset) wb_wval = (l_op == IOPBITS'(LW_I)) ? l_rd : l_alu;
  end

  always_comb begin
    state_d     = state_q;
    retired_d   = retired_q;
    last_pc_d   = last_pc_q;
    expect_d    = expect_q;
    order_err_d = order_err_q;
    if (commit) begin
      retired_d = retired_q + DBITS'(1);
      last_pc_d = l_pc;
      // Resync to the observed count so one gap flags once, not forever
      expect_d  = l_ic + DBITS'(1);
      if (l_ic != expect_q) order_err_d = 1'b1;
      if (l_inst == HALT_INST) state_d = HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      retired_q   <= '0;
      last_pc_q   <= '0;
      expect_q    <= '0;
      order_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      last_pc_q   <= last_pc_d;
      expect_q    <= expect_d;
      order_err_q <= order_err_d;
    end
  end

  assign halted        = (state_q == HALTED);
  assign from_WB_to_FE = halted;
  assign retired_count = retired_q;
  assign last_pc       = last_pc_q;
  assign order_err     = order_err_q;

`ifdef WB_COMMIT_HIST_EN
  wb_commit_hist #(
    .DBITS      (DBITS),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk     (clk),
    .reset   (reset),
    .push    (commit),
    .push_pc (l_pc),
    .rd_idx  (hist_idx),
    .rd_pc   (hist_pc)
  );
`else
  logic unused_hist_idx;
  assign unused_hist_idx = ^hist_idx;
  assign hist_pc         = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed test-plan steps plus randomized
// traffic compared against a queue-based retirement model.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int unsigned LATCH_W = 1 + 32 + 4*32 + 6 + 5 + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [LATCH_W-1:0] latch = '0;
  logic               wb_wr_en, from_WB_to_FE, halted, order_err;
  logic [4:0]         wb_wregno;
  logic [31:0]        wb_wval, retired_count, last_pc, hist_pc;
  logic [2:0]         hist_idx = '0;

  wb_stage dut (
    .clk            (clk),
    .reset          (reset),
    .from_MEM_latch (latch),
    .wb_wr_en       (wb_wr_en),
    .wb_wregno      (wb_wregno),
    .wb_wval        (wb_wval),
    .from_WB_to_FE  (from_WB_to_FE),
    .retired_count  (retired_count),
    .last_pc        (last_pc),
    .halted         (halted),
    .order_err      (order_err),
    .hist_idx       (hist_idx),
    .hist_pc        (hist_pc)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: committed-PC list plus retirement summary
  logic [31:0] pcq[$];
  logic [31:0] m_cnt, m_pc, m_next;
  logic        m_err, m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hist_exp(input int idx);
    logic [31:0] r;
    r = '0;
`ifdef WB_COMMIT_HIST_EN
    if (idx < pcq.size()) r = pcq[pcq.size() - 1 - idx];
`endif
    return r;
  endfunction

  task automatic model_reset();
    pcq.delete();
    m_cnt = '0; m_pc = '0; m_next = '0; m_err = 1'b0; m_halt = 1'b0;
  endtask

  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [5:0] op, input logic [31:0] alu, input logic [4:0] rn,
                      input logic wr, input logic [31:0] ic, input logic [31:0] rd);
    logic commit, exp_en;
    int   hi;
    @(negedge clk);
    latch    = {v, inst, pc, op, alu, rn, wr, ic, rd};
    hi       = int'($urandom_range(0, 7));
    hist_idx = 3'(hi);
    #1;
    commit = v && !m_halt && !reset;
    exp_en = commit && wr && (rn != 0);
    chk("wr_en", {31'b0, wb_wr_en}, {31'b0, exp_en});
    if (exp_en) begin
      chk("wregno", {27'b0, wb_wregno}, {27'b0, rn});
      chk("wval", wb_wval, (op == LW_I) ? rd : alu);
    end
    chk("hist_pc", hist_pc, hist_exp(hi));
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else if (commit) begin
      if (ic != m_next) m_err = 1'b1;
      m_next = ic + 1;
      m_cnt  = m_cnt + 1;
      m_pc   = pc;
      pcq.push_back(pc);
      if (inst == HALT_INST_DEF) m_halt = 1'b1;
    end
    chk("retired", retired_count, m_cnt);
    chk("last_pc", last_pc, m_pc);
    chk("order_err", {31'b0, order_err}, {31'b0, m_err});
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    chk("to_fe", {31'b0, from_WB_to_FE}, {31'b0, m_halt});
  endtask

  task automatic bubble();
    step(1'b0, $urandom, $urandom, ADD_I, $urandom, 5'd9, 1'b1, m_next, $urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 32'h13, 32'h900, ADD_I, 32'h55, 5'd4, 1'b1, 32'd0, 32'h0);
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] inst, ic;
    logic [5:0]  op;
    logic [4:0]  rn;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    chk("rst_retired", retired_count, 32'd0);

    // ALU commit, load select, x0 suppression, bubble, store
    step(1'b1, 32'h0053_0293, 32'h100, ADD_I, 32'h1234, 5'd5, 1'b1, 32'd0, 32'h0);
    chk("alu_retired", retired_count, 32'd1);
    chk("alu_last_pc", last_pc, 32'h100);
    step(1'b1, 32'h0000_2183, 32'h104, LW_I, 32'h40, 5'd3, 1'b1, 32'd1, 32'hDEAD_BEEF);
    step(1'b1, 32'h0000_2003, 32'h108, LW_I, 32'h40, 5'd0, 1'b1, 32'd2, 32'hDEAD_BEEF);
    bubble();
    step(1'b1, 32'h0000_2023, 32'h10C, SW_I, 32'h80, 5'd6, 1'b0, 32'd3, 32'h0);
    chk("seq_retired", retired_count, 32'd4);

    // Order error: 0, 1, 3, 4
    do_reset();
    step(1'b1, 32'h13, 32'h0, ADD_I, 32'h1, 5'd1, 1'b1, 32'd0, 32'h0);
    step(1'b1, 32'h13, 32'h4, ADD_I, 32'h2, 5'd1, 1'b1, 32'd1, 32'h0);
    chk("order_ok", {31'b0, order_err}, 32'd0);
    step(1'b1, 32'h13, 32'h8, ADD_I, 32'h3, 5'd1, 1'b1, 32'd3, 32'h0);
    chk("order_rise", {31'b0, order_err}, 32'd1);
    step(1'b1, 32'h13, 32'hC, ADD_I, 32'h4, 5'd1, 1'b1, 32'd4, 32'h0);
    chk("order_sticky", {31'b0, order_err}, 32'd1);
    chk("order_retired", retired_count, 32'd4);

    // Randomized traffic with occasional halts and mid-run resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0) begin
        do_reset();
        continue;
      end
      case ($urandom_range(0, 3))
        0: op = ADD_I;
        1: op = LW_I;
        2: op = SW_I;
        default: op = 6'($urandom);
      endcase
      inst = $urandom;
      if ($urandom_range(0, 39) == 0) inst = HALT_INST_DEF;
      else if (inst == HALT_INST_DEF) inst = inst ^ 32'h1;
      rn = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ic = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 500) : m_next;
      step(($urandom_range(0, 4) != 0), inst, $urandom & 32'hFFFF_FFFC, op, $urandom,
           rn, 1'($urandom), ic, $urandom);
    end

    // Halt at count 9 after PCs 0x0..0x20, then a valid ADD x7
    do_reset();
    for (int i = 0; i < 9; i++)
      step(1'b1, 32'h13, 32'(4 * i), ADD_I, 32'(i), 5'd2, 1'b1, 32'(i), 32'h0);
    step(1'b1, HALT_INST_DEF, 32'h24, ADD_I, 32'h0, 5'd0, 1'b0, 32'd9, 32'h0);
    chk("halt_flag", {31'b0, halted}, 32'd1);
    chk("halt_retired", retired_count, 32'd10);
    chk("halt_last_pc", last_pc, 32'h24);
    step(1'b1, 32'h0010_0393, 32'h28, ADD_I, 32'h77, 5'd7, 1'b1, 32'd10, 32'h0);
    chk("post_halt_retired", retired_count, 32'd10);

    @(negedge clk);
    hist_idx = 3'd0;
    #1;
`ifdef WB_COMMIT_HIST_EN
    chk("hist_newest", hist_pc, 32'h24);
`else
    chk("hist_newest", hist_pc, 32'h0);
`endif
    hist_idx = 3'd7;
    #1;
`ifdef WB_COMMIT_HIST_EN
    chk("hist_wrap", hist_pc, 32'h8);
`else
    chk("hist_wrap", hist_pc, 32'h0);
`endif

    do_reset();
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fe", {31'b0, from_WB_to_FE}, 32'd0);
    chk("rst_last_pc", last_pc, 32'd0);
    chk("rst_cnt", retired_count, 32'd0);
    step(1'b1, 32'h13, 32'h40, ADD_I, 32'h99, 5'd8, 1'b1, 32'd0, 32'h0);
    chk("run_after_reset", retired_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
